// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared FSM state type and default parameters for irq_ctrl_param
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        ACTIVE = 2'd2,
        EXIT   = 2'd3
    } irq_state_e;

    localparam int IRQ_MAX        = 16;
    localparam int NUM_IRQ_DEF    = 8;
    localparam int IDX_W_DEF      = 4;
    localparam int DEB_CYCLES_DEF = 16;

endpackage

// File: rtl/irq_src_cond.sv
// rtl/irq_src_cond.sv - per-source sync, optional debounce (IRQ_DEBOUNCE_EN), rise detect
module irq_src_cond #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic level,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic filt;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

`ifdef IRQ_DEBOUNCE_EN
    logic [7:0] cnt;

    // The filter flips only once the synchronised input has disagreed with it
    // for DEB_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= 8'd0;
        end else if (sync2 != filt) begin
            if (cnt == 8'(DEB_CYCLES - 1)) begin
                filt <= sync2;
                cnt  <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            cnt <= 8'd0;
        end
    end
`else
    assign filt = sync2;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= filt;
        end
    end

    assign level = filt;
    assign rise  = filt & ~prev;

endmodule

// File: rtl/irq_ctrl_param.sv
// rtl/irq_ctrl_param.sv - fixed-priority interrupt controller with trap entry/exit FSM (IRQ_DEBOUNCE_EN)
module irq_ctrl_param
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ    = NUM_IRQ_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [NUM_IRQ-1:0] irq_level,
    input  logic               int_mstatus_mie,
    input  logic               mret_en,
    output logic               trap_entry_en,
    output logic               trap_exit_en,
    output logic [IDX_W-1:0]   int_index,
    output logic [NUM_IRQ-1:0] irq_pending
);

    logic [NUM_IRQ-1:0] lvl;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] sel;
    logic [NUM_IRQ-1:0] clr;
    logic [IDX_W-1:0]   win;
    logic               take;
    irq_state_e         state;
    irq_state_e         state_nxt;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
        irq_src_cond #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_cond (
            .clk  (clk),
            .rst_n(rst_n),
            .src  (irq_src[i]),
            .level(lvl[i]),
            .rise (rise[i])
        );
    end

    assign irq_pending = (irq_level & lvl) | (~irq_level & edge_pend);
    assign sel         = irq_pending & irq_mask;
    assign take        = (state == IDLE) && int_mstatus_mie && (|sel);

    // Scan downward so the lowest selectable index is the last one written.
    always_comb begin
        win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (sel[i]) begin
                win = IDX_W'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = take && (win == IDX_W'(i));
        end
    end

    // A new rise wins over a simultaneous clear so no edge is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_pend <= '0;
        end else begin
            edge_pend <= (edge_pend & ~clr) | rise;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ENTRY;
            ENTRY:   state_nxt = ACTIVE;
            ACTIVE:  if (mret_en) state_nxt = EXIT;
            EXIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            int_index <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                int_index <= win;
            end
        end
    end

    assign trap_entry_en = (state == ENTRY);
    assign trap_exit_en  = (state == EXIT);

endmodule

// File: tb/tb_irq_ctrl_param.sv
// tb/tb_irq_ctrl_param.sv - randomized self-checking bench for irq_ctrl_param
module tb_irq_ctrl_param;

    localparam int DEB = 8;
`ifdef IRQ_DEBOUNCE_EN
    localparam int LAT = 4 + DEB;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_src;
    logic [7:0] irq_mask;
    logic [7:0] irq_level;
    logic       int_mstatus_mie;
    logic       mret_en;
    logic       trap_entry_en;
    logic       trap_exit_en;
    logic [3:0] int_index;
    logic [7:0] irq_pending;

    int checks = 0;
    int errors = 0;

    irq_ctrl_param #(
        .NUM_IRQ(8),
        .IDX_W(4),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src        (irq_src),
        .irq_mask       (irq_mask),
        .irq_level      (irq_level),
        .int_mstatus_mie(int_mstatus_mie),
        .mret_en        (mret_en),
        .trap_entry_en  (trap_entry_en),
        .trap_exit_en   (trap_exit_en),
        .int_index      (int_index),
        .irq_pending    (irq_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq_src = '0;
        irq_mask = 8'hff;
        irq_level = '0;
        int_mstatus_mie = 1'b1;
        mret_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Returns the tick count (1-based) at which trap_entry_en is first seen, or -1.
    task automatic wait_entry(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (trap_entry_en === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        int exits;
        do_reset();
        checks++;
        if (trap_entry_en !== 1'b0 || trap_exit_en !== 1'b0 || int_index !== 4'd0 || irq_pending !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: entry=%b exit=%b idx=%0d pend=%h, required 0/0/0/00",
                     trap_entry_en, trap_exit_en, int_index, irq_pending);
        end
        exits = 0;
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (trap_exit_en) exits++;
            tick();
        end
        checks++;
        if (exits != 0) begin
            errors++;
            $display("FAIL mret_in_idle: exit pulses=%0d, required 0", exits);
        end
    endtask

    task automatic test_edge_latency();
        int n;
        do_reset();
        irq_src[3] = 1'b1;
        wait_entry(LAT + 4, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL edge_latency: entry at tick %0d, required %0d", n, LAT);
        end
        checks++;
        if (int_index !== 4'd3) begin
            errors++;
            $display("FAIL edge_index: idx=%0d, required 3", int_index);
        end
        checks++;
        if (irq_pending[3] !== 1'b0) begin
            errors++;
            $display("FAIL edge_pend_clear: pend=%h, required bit3=0", irq_pending);
        end
        // mret during ENTRY must be ignored
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        checks++;
        if (trap_entry_en !== 1'b0 || trap_exit_en !== 1'b0) begin
            errors++;
            $display("FAIL entry_one_cycle: entry=%b exit=%b, required 0/0", trap_entry_en, trap_exit_en);
        end
        tick();
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        checks++;
        if (trap_exit_en !== 1'b1) begin
            errors++;
            $display("FAIL exit_pulse: exit=%b, required 1", trap_exit_en);
        end
        tick();
        checks++;
        if (trap_exit_en !== 1'b0 || int_index !== 4'd3) begin
            errors++;
            $display("FAIL exit_one_cycle: exit=%b idx=%0d, required 0/3", trap_exit_en, int_index);
        end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        irq_src[1] = 1'b1;
        irq_src[5] = 1'b1;
        wait_entry(LAT + 4, n);
        checks++;
        if (n != LAT || int_index !== 4'd1 || irq_pending !== 8'h20) begin
            errors++;
            $display("FAIL prio_first: tick=%0d idx=%0d pend=%h, required %0d/1/20", n, int_index, irq_pending, LAT);
        end
        tick();
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        checks++;
        if (trap_exit_en !== 1'b1) begin
            errors++;
            $display("FAIL prio_exit: exit=%b, required 1", trap_exit_en);
        end
        wait_entry(6, n);
        checks++;
        if (n != 2 || int_index !== 4'd5 || irq_pending !== 8'h00) begin
            errors++;
            $display("FAIL prio_second: tick=%0d idx=%0d pend=%h, required 2/5/00", n, int_index, irq_pending);
        end
    endtask

    task automatic test_mie_gate();
        int entries;
        do_reset();
        int_mstatus_mie = 1'b0;
        irq_src[2] = 1'b1;
        entries = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (trap_entry_en) entries++;
        end
        checks++;
        if (entries != 0 || irq_pending[2] !== 1'b1) begin
            errors++;
            $display("FAIL mie_blocked: entries=%0d pend=%h, required 0 and bit2=1", entries, irq_pending);
        end
        int_mstatus_mie = 1'b1;
        tick();
        checks++;
        if (trap_entry_en !== 1'b1 || int_index !== 4'd2) begin
            errors++;
            $display("FAIL mie_release: entry=%b idx=%0d, required 1/2", trap_entry_en, int_index);
        end
    endtask

    task automatic test_level_glitch();
        int n;
        int seen;
        int entries;
        do_reset();
        irq_level[0] = 1'b1;
        irq_src[4] = 1'b1;
        wait_entry(LAT + 4, n);
        tick();
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            tick();
            if (irq_pending[0]) seen++;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL level_follow: pending[0] high for %0d cycles, required 1", seen);
        end
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        entries = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (trap_entry_en) entries++;
        end
        checks++;
        if (entries != 0 || irq_pending !== 8'h00) begin
            errors++;
            $display("FAIL level_no_entry: entries=%0d pend=%h, required 0/00", entries, irq_pending);
        end
    endtask

    task automatic test_reset_active();
        int n;
        int exits;
        do_reset();
        irq_src[6] = 1'b1;
        wait_entry(LAT + 4, n);
        tick();
        rst_n = 1'b0;
        mret_en = 1'b1;
        irq_src = '0;
        tick();
        checks++;
        if (trap_entry_en !== 1'b0 || trap_exit_en !== 1'b0 || int_index !== 4'd0 || irq_pending !== 8'h00) begin
            errors++;
            $display("FAIL reset_active: entry=%b exit=%b idx=%0d pend=%h, required 0/0/0/00",
                     trap_entry_en, trap_exit_en, int_index, irq_pending);
        end
        rst_n = 1'b1;
        mret_en = 1'b0;
        exits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (trap_exit_en || trap_entry_en) exits++;
        end
        checks++;
        if (exits != 0) begin
            errors++;
            $display("FAIL reset_active_quiet: pulses=%0d, required 0", exits);
        end
    endtask

    task automatic test_random();
        logic [7:0] set;
        logic [7:0] mask;
        logic [7:0] sel;
        logic [7:0] exp_pend;
        int n;
        int w;
        int first;
        int entries;
        for (int t = 0; t < 16; t++) begin
            set  = 8'($urandom_range(1, 255));
            mask = 8'($urandom);
            do_reset();
            irq_mask = mask;
            irq_src  = set;
            sel      = set & mask;
            exp_pend = set;
            first    = 1;
            while (sel != 0) begin
                w = lowest(sel);
                wait_entry(first ? LAT + 3 : 5, n);
                checks++;
                if (n != (first ? LAT : 2) || int_index !== 4'(w)) begin
                    errors++;
                    $display("FAIL rand_entry: set=%h mask=%h tick=%0d idx=%0d, required %0d/%0d",
                             set, mask, n, int_index, first ? LAT : 2, w);
                end
                exp_pend[w] = 1'b0;
                sel[w] = 1'b0;
                checks++;
                if (irq_pending !== exp_pend) begin
                    errors++;
                    $display("FAIL rand_pend: pend=%h, required %h", irq_pending, exp_pend);
                end
                repeat (1 + $urandom_range(0, 3)) tick();
                mret_en = 1'b1;
                tick();
                mret_en = 1'b0;
                checks++;
                if (trap_exit_en !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_exit: exit=%b, required 1", trap_exit_en);
                end
                first = 0;
            end
            entries = 0;
            for (int i = 0; i < LAT + 4; i++) begin
                tick();
                if (trap_entry_en) entries++;
            end
            checks++;
            if (entries != 0 || irq_pending !== (set & ~mask)) begin
                errors++;
                $display("FAIL rand_tail: entries=%0d pend=%h, required 0/%h", entries, irq_pending, set & ~mask);
            end
        end
    endtask

`ifdef IRQ_DEBOUNCE_EN
    task automatic test_debounce();
        int n;
        do_reset();
        int_mstatus_mie = 1'b0;
        irq_src[7] = 1'b1;
        repeat (5) tick();
        irq_src[7] = 1'b0;
        repeat (20) tick();
        checks++;
        if (irq_pending !== 8'h00) begin
            errors++;
            $display("FAIL deb_glitch: pend=%h, required 00", irq_pending);
        end
        irq_src[7] = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (irq_pending[7]) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 3 + DEB) begin
            errors++;
            $display("FAIL deb_stable: pending at tick %0d, required %0d", n, 3 + DEB);
        end
    endtask
`else
    task automatic test_debounce();
        int n;
        do_reset();
        int_mstatus_mie = 1'b0;
        irq_src[7] = 1'b1;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            irq_src[7] = 1'b0;
            if (irq_pending[7]) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL nodeb_pulse: pending at tick %0d, required 3", n);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_mie_gate();
        test_level_glitch();
        test_reset_active();
        test_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
